// File: rtl/move_arbiter_if.sv
// Signal bundle between the move sources, game_fsm and the move arbiter.
// The arbiter attaches through the slave modport; the environment drives the master side.
interface move_arbiter_if;
  logic       my_color;
  logic       turn;
  logic       game_over;
  logic       invalid_move;
  logic       local_valid;
  logic [7:0] local_move;
  logic       local_ready;
  logic       remote_valid;
  logic [7:0] remote_move;
  logic       remote_ready;
  logic       move_avail;
  logic [7:0] move;
  logic       busy;
  logic       result_valid;
  logic       result_src;
  logic [1:0] result_code;

  modport slave (
    input  my_color, turn, game_over, invalid_move,
    input  local_valid, local_move, remote_valid, remote_move,
    output local_ready, remote_ready, move_avail, move, busy,
    output result_valid, result_src, result_code
  );

  modport master (
    output my_color, turn, game_over, invalid_move,
    output local_valid, local_move, remote_valid, remote_move,
    input  local_ready, remote_ready, move_avail, move, busy,
    input  result_valid, result_src, result_code
  );
endinterface

// File: rtl/move_arbiter.sv
// Arbitrates local/remote move requests, screens bad ones, issues moves to game_fsm
// and reports game_fsm's verdict (or a timeout) back to the requesting source.
module move_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           clk_in,
  input  logic           reset,
  move_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             issued_turn;
  logic             src_q;
  logic [1:0]       code_q;
  logic [7:0]       move_q;

  logic       on_local;
  logic       grant_local, grant_remote, xfer;
  logic [7:0] xfer_move;
  logic       bad_req, wait_done;

  function automatic logic off_board(input logic [7:0] m);
    return (m != 8'hFF) && ((m[7:4] > 4'd8) || (m[3:0] > 4'd8));
  endfunction

  // The on-turn source wins when both are requesting.
  always_comb begin
    on_local     = (bus.turn == bus.my_color);
    grant_local  = (state == IDLE) && bus.local_valid  && (on_local  || !bus.remote_valid);
    grant_remote = (state == IDLE) && bus.remote_valid && (!on_local || !bus.local_valid);
    xfer         = grant_local || grant_remote;
    xfer_move    = grant_remote ? bus.remote_move : bus.local_move;
    bad_req      = bus.game_over || (grant_remote ? on_local : !on_local) || off_board(xfer_move);
    wait_done    = bus.invalid_move || (bus.turn != issued_turn) || (cnt == CNT_LAST);
  end

  always_ff @(posedge clk_in) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = bad_req ? RESPOND : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_done) state_nxt = RESPOND;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.local_ready  = grant_local;
    bus.remote_ready = grant_remote;
    bus.move_avail   = (state == ISSUE);
    bus.busy         = (state != IDLE);
    bus.result_valid = (state == RESPOND);
  end

  assign bus.move        = move_q;
  assign bus.result_src  = src_q;
  assign bus.result_code = code_q;

  // Capture on the transfer edge so move is already stable in the issue cycle.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      move_q      <= 8'hFF;
      src_q       <= 1'b0;
      code_q      <= 2'b00;
      cnt         <= '0;
      issued_turn <= 1'b0;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          src_q       <= grant_remote;
          issued_turn <= bus.turn;
          if (bad_req) code_q <= 2'b10;
          else         move_q <= xfer_move;
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus.invalid_move)              code_q <= 2'b01;
          else if (bus.turn != issued_turn)  code_q <= 2'b00;
          else if (cnt == CNT_LAST)          code_q <= 2'b11;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_move_arbiter.sv
// Randomized bench for move_arbiter against a transaction-level model of the arbitration rules.
module tb_move_arbiter;
  localparam int T = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [7:0] last_move = 8'hFF;

  move_arbiter_if bus ();

  move_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk_in (clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic model_off_board(input logic [7:0] m);
    int row, col;
    row = m / 16;
    col = m % 16;
    return (m != 8'hFF) && (row > 8 || col > 8);
  endfunction

  function automatic logic [7:0] rand_move();
    case ($urandom_range(0, 3))
      0:       return 8'hFF;
      1:       return 8'($urandom_range(0, 255));
      default: return 8'($urandom_range(0, 8) * 16 + $urandom_range(0, 8));
    endcase
  endfunction

  // kind: 0 no response, 1 invalid_move, 2 turn toggle, 3 both; r = WAIT cycle index of the response
  task automatic run_txn(input logic mc, input logic tn, input logic go,
                         input logic lv, input logic [7:0] lm,
                         input logic rv, input logic [7:0] rm,
                         input int r, input int kind);
    logic prefer_remote, pick_remote, is_bad, in_time;
    logic [7:0] pick_move;
    logic [1:0] exp_code;
    int last_k;

    @(negedge clk);
    bus.my_color = mc; bus.turn = tn; bus.game_over = go; bus.invalid_move = 1'b0;
    bus.local_valid = lv; bus.local_move = lm;
    bus.remote_valid = rv; bus.remote_move = rm;
    #1;
    prefer_remote = (tn != mc);
    if (prefer_remote) pick_remote = rv ? 1'b1 : 1'b0;
    else               pick_remote = lv ? 1'b0 : 1'b1;
    pick_move = pick_remote ? rm : lm;
    is_bad = go || (pick_remote != prefer_remote) || model_off_board(pick_move);
    chk("hs_busy", bus.busy, 0);
    chk("hs_local_ready", bus.local_ready, !pick_remote);
    chk("hs_remote_ready", bus.remote_ready, pick_remote);
    chk("hs_move_avail", bus.move_avail, 0);

    @(negedge clk);
    bus.local_valid = 1'b0; bus.remote_valid = 1'b0;
    bus.local_move = 8'($urandom_range(0, 255)); bus.remote_move = 8'($urandom_range(0, 255));
    #1;
    chk("p1_ready", {bus.local_ready, bus.remote_ready}, 0);
    if (is_bad) begin
      chk("bad_result_valid", bus.result_valid, 1);
      chk("bad_result_src", bus.result_src, pick_remote);
      chk("bad_result_code", bus.result_code, 2'b10);
      chk("bad_move_avail", bus.move_avail, 0);
      chk("bad_move_kept", bus.move, last_move);
      return;
    end

    chk("issue_move_avail", bus.move_avail, 1);
    chk("issue_move", bus.move, pick_move);
    chk("issue_result_valid", bus.result_valid, 0);
    last_move = pick_move;

    in_time  = (kind != 0) && (r <= T - 1);
    last_k   = in_time ? r : T - 1;
    exp_code = !in_time ? 2'b11 : (kind == 2 ? 2'b00 : 2'b01);
    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk);
      bus.invalid_move = 1'b0;
      if (in_time && k == r) begin
        if (kind != 2) bus.invalid_move = 1'b1;
        if (kind != 1) bus.turn = ~bus.turn;
        if (kind == 2) bus.game_over = 1'($urandom_range(0, 1));
      end
      #1;
      chk("wait_busy", bus.busy, 1);
      chk("wait_result_valid", bus.result_valid, 0);
      chk("wait_move_avail", bus.move_avail, 0);
    end

    @(negedge clk);
    bus.invalid_move = 1'b0;
    #1;
    chk("resp_result_valid", bus.result_valid, 1);
    chk("resp_result_src", bus.result_src, pick_remote);
    chk("resp_result_code", bus.result_code, exp_code);
    chk("resp_move_stable", bus.move, last_move);
  endtask

  initial begin
    bus.my_color = 1'b0; bus.turn = 1'b0; bus.game_over = 1'b0; bus.invalid_move = 1'b0;
    bus.local_valid = 1'b0; bus.local_move = 8'h00;
    bus.remote_valid = 1'b0; bus.remote_move = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_move", bus.move, 8'hFF);
    chk("rst_move_avail", bus.move_avail, 0);
    chk("rst_result_valid", bus.result_valid, 0);
    chk("rst_result_src", bus.result_src, 0);
    chk("rst_result_code", bus.result_code, 0);
    chk("rst_ready", {bus.local_ready, bus.remote_ready}, 0);
    reset = 1'b0;

    run_txn(0, 0, 0, 1, 8'h34, 0, 8'h00, 2, 2);
    run_txn(0, 1, 0, 1, 8'h12, 1, 8'h45, 0, 2);
    run_txn(0, 0, 0, 1, 8'h12, 0, 8'h00, 1, 2);
    run_txn(0, 1, 0, 1, 8'h39, 0, 8'h00, 0, 2);
    run_txn(0, 1, 0, 1, 8'h90, 1, 8'h90, 0, 2);
    run_txn(0, 0, 0, 0, 8'h00, 1, 8'h11, 0, 2);
    run_txn(0, 0, 1, 1, 8'h11, 0, 8'h00, 0, 2);
    run_txn(0, 0, 0, 1, 8'h22, 0, 8'h00, 2, 1);
    run_txn(1, 1, 0, 1, 8'h88, 0, 8'h00, 1, 3);
    run_txn(0, 0, 0, 1, 8'h05, 0, 8'h00, 0, 0);
    run_txn(1, 0, 0, 0, 8'h00, 1, 8'hFF, 3, 2);

    for (int i = 0; i < 200; i++) begin
      int sel;
      sel = $urandom_range(1, 3);
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
              sel[0], rand_move(), sel[1], rand_move(),
              $urandom_range(0, 5), $urandom_range(0, 3));
    end

    // Abort mid-WAIT with reset: no result pulse, back to IDLE with move cleared.
    @(negedge clk);
    bus.my_color = bus.turn; bus.game_over = 1'b0; bus.invalid_move = 1'b0;
    bus.local_valid = 1'b1; bus.local_move = 8'h22; bus.remote_valid = 1'b0;
    @(negedge clk);
    bus.local_valid = 1'b0;
    #1;
    chk("abort_issue", bus.move_avail, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_pre_busy", bus.busy, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_move", bus.move, 8'hFF);
    chk("abort_result_valid", bus.result_valid, 0);
    @(negedge clk);
    #1;
    chk("abort_no_late_result", bus.result_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/move_arbiter.md
Name: move_arbiter

Overview:
- Sits between the two move sources and game_fsm. The sources are the local player UI (cursor/button) and the remote player (UART receive path).
- Accepts one move request at a time using a valid/ready handshake per source, and screens out bad requests (out of turn, off board, game over).
- Issues each accepted move to game_fsm as a one-cycle move_avail pulse with a stable move byte.
- Waits for game_fsm's verdict, then reports a result code back to the requesting source.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum number of WAIT cycles before an issued move is declared timed out. Must be >= 2.

Ports:
- clk_in  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- my_color  input  1  colour played by the local source (0 = black, 1 = white). The remote source plays ~my_color.
- turn  input  1  side to move, from game_fsm.
- game_over  input  1  from game_fsm.
- invalid_move  input  1  rule rejection, from game_fsm.
- local_valid  input  1  local request present.
- local_move  input  8  local move: [7:4] = row, [3:0] = col, 8'hFF = pass.
- local_ready  output  1  local request accepted this cycle when local_valid & local_ready.
- remote_valid  input  1  remote request present.
- remote_move  input  8  remote move, same encoding as local_move.
- remote_ready  output  1  remote accept.
- move_avail  output  1  one-cycle issue strobe to game_fsm.
- move  output  8  move to game_fsm. Held stable from the issue cycle until the next issue.
- busy  output  1  high in every state except IDLE.
- result_valid  output  1  one-cycle result strobe.
- result_src  output  1  source of the reported result: 0 = local, 1 = remote.
- result_code  output  2  00 accepted, 01 rejected by rules, 10 bad request, 11 timeout.

Behaviour:
- Reset values: local_ready = 0, remote_ready = 0, move_avail = 0, move = 8'hFF, busy = 0, result_valid = 0, result_src = 0, result_code = 00, timeout counter = 0, state = IDLE.
- Reset asserted mid-operation aborts the operation with no result pulse. The state returns to IDLE the next cycle.
- States: IDLE, ISSUE, WAIT, RESPOND.

IDLE:
- The on-turn source is local when turn == my_color, otherwise remote.
- If the on-turn source is valid, raise its ready combinationally. The off-turn source's ready stays 0.
- Otherwise, if the off-turn source is valid, raise its ready.
- At most one transfer per cycle. On a transfer, capture the move, the source, and the current turn (issued_turn).

Bad-request screening on the transfer cycle:
- A request is bad if game_over = 1, or the source is off turn, or the move is not 8'hFF and (row > 8 or col > 8).
- A bad request goes to RESPOND with code 10. Nothing is issued.
- A good request goes to ISSUE.

ISSUE (one cycle):
- move <= captured move; move_avail = 1; clear the counter; go to WAIT.
- Latency: handshake in cycle N, move_avail in cycle N+1.

WAIT:
- move_avail = 0; the counter increments each cycle.
- invalid_move = 1: code 01 → RESPOND.
- Otherwise, turn != issued_turn: code 00 → RESPOND. This covers both placements and passes.
- invalid_move and a turn change in the same cycle: code 01 wins.
- Otherwise, counter == TIMEOUT_CYCLES-1: code 11 → RESPOND.
- game_over rising during WAIT is not a result by itself. A pass that ends the game still toggles turn and reports 00.

RESPOND (one cycle):
- result_valid = 1, with result_src and result_code driven from the captured values; then go to IDLE.
- A bad request therefore produces result_valid at N+1.
- Both ready outputs are 0 outside IDLE. A new handshake is possible the cycle after RESPOND.
- move is not modified by bad requests or by reset-free aborts; it keeps its last issued value.

Test Plan:
- my_color = 0, turn = 0, local_valid with local_move = 8'h34 at cycle N → local_ready = 1 at N; move_avail = 1 and move = 8'h34 at N+1. Toggling turn at N+4 → result_valid at N+5 with src 0, code 00.
- Both sources valid, turn = 1, my_color = 0 → remote accepted and local_ready = 0. The local request is accepted in the first IDLE cycle after the remote result.
- local_move = 8'h39 (col 9) or 8'h90 → no move_avail; result_valid at N+1 with code 10. move is unchanged.
- Remote request while turn == my_color → code 10 at N+1. game_over = 1 with a valid local request → code 10.
- Issued 8'h22, invalid_move pulse 3 cycles later → code 01. Same-cycle invalid_move and turn toggle → code 01.
- No response after issue with TIMEOUT_CYCLES = 4 → code 11 exactly 4 WAIT cycles after the issue. Reset during WAIT → no result_valid, busy = 0 next cycle, move = 8'hFF.
